// File: rtl/cotm32_pkg.sv
// Shared types for the processor core's memory-side blocks.
// Holds the arbiter's state and owner encodings plus the starve counter width.
package cotm32_pkg;

    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_OWN_IF = 1'b0,
        ARB_OWN_D  = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arb_select.sv
// Fetch/data priority pick with a saturating starve counter; combinational pick, counter registered.
// The pick is only committed when i_arbitrate is high; no backpressure of its own.
module mem_arb_select
    import cotm32_pkg::*;
#(
    parameter int MAX_STARVE = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_if_req,
    input  logic       i_d_req,
    input  logic       i_arbitrate,
    output arb_owner_t o_owner,
    output logic       o_has_winner
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(MAX_STARVE);

    logic [STARVE_W-1:0] starve_q;
    logic                fetch_forced;

    // Fetch overrides data priority once data has won MAX_STARVE times in a row.
    assign fetch_forced = i_if_req && (starve_q == STARVE_LIM);
    assign o_owner      = (i_d_req && !fetch_forced) ? ARB_OWN_D : ARB_OWN_IF;
    assign o_has_winner = i_if_req || i_d_req;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            starve_q <= '0;
        end else if (i_arbitrate && o_has_winner) begin
            if ((o_owner == ARB_OWN_D) && i_if_req) begin
                if (starve_q != STARVE_LIM) begin
                    starve_q <= starve_q + 1'b1;
                end
            end else begin
                starve_q <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between fetch and load/store, one transaction in flight, data first.
// Request reaches o_m_req one cycle after arbitration; held until i_m_gnt, response routed to owner.
module mem_bus_arbiter
    import cotm32_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STARVE = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic                o_if_gnt,
    output logic                o_if_rvalid,
    output logic [DATA_W-1:0]   o_if_rdata,
    input  logic                i_d_req,
    input  logic                i_d_we,
    input  logic [DATA_W/8-1:0] i_d_be,
    input  logic [ADDR_W-1:0]   i_d_addr,
    input  logic [DATA_W-1:0]   i_d_wdata,
    output logic                o_d_gnt,
    output logic                o_d_rvalid,
    output logic [DATA_W-1:0]   o_d_rdata,
    output logic                o_m_req,
    output logic                o_m_we,
    output logic [DATA_W/8-1:0] o_m_be,
    output logic [ADDR_W-1:0]   o_m_addr,
    output logic [DATA_W-1:0]   o_m_wdata,
    input  logic                i_m_gnt,
    input  logic                i_m_rvalid,
    input  logic [DATA_W-1:0]   i_m_rdata,
    output logic                o_busy
);

    arb_state_t state_q;
    arb_state_t state_d;
    arb_owner_t owner_q;
    arb_owner_t owner_nxt;
    logic       arbitrate;
    logic       has_winner;

    // A new owner may be picked while idle or in the very cycle the current response lands.
    assign arbitrate = (state_q == ARB_IDLE) || ((state_q == ARB_RESP) && i_m_rvalid);

    mem_arb_select #(
        .MAX_STARVE (MAX_STARVE)
    ) u_select (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_if_req     (i_if_req),
        .i_d_req      (i_d_req),
        .i_arbitrate  (arbitrate),
        .o_owner      (owner_nxt),
        .o_has_winner (has_winner)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ARB_IDLE;
            owner_q <= ARB_OWN_IF;
        end else begin
            state_q <= state_d;
            if (arbitrate && has_winner) begin
                owner_q <= owner_nxt;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (has_winner) begin
                    state_d = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (i_m_gnt) begin
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                if (i_m_rvalid) begin
                    state_d = has_winner ? ARB_REQ : ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Bus fields are a pure mux of the owner's held inputs; the other port is masked.
    always_comb begin
        o_if_gnt    = 1'b0;
        o_if_rvalid = 1'b0;
        o_if_rdata  = '0;
        o_d_gnt     = 1'b0;
        o_d_rvalid  = 1'b0;
        o_d_rdata   = '0;
        o_m_req     = 1'b0;
        o_m_we      = 1'b0;
        o_m_be      = '0;
        o_m_addr    = '0;
        o_m_wdata   = '0;
        o_busy      = (state_q != ARB_IDLE);
        case (state_q)
            ARB_REQ: begin
                o_m_req = 1'b1;
                if (owner_q == ARB_OWN_D) begin
                    o_m_we    = i_d_we;
                    o_m_be    = i_d_be;
                    o_m_addr  = i_d_addr;
                    o_m_wdata = i_d_wdata;
                    o_d_gnt   = i_m_gnt;
                end else begin
                    o_m_be    = '1;
                    o_m_addr  = i_if_addr;
                    o_if_gnt  = i_m_gnt;
                end
            end
            ARB_RESP: begin
                if (owner_q == ARB_OWN_D) begin
                    o_d_rvalid = i_m_rvalid;
                    o_d_rdata  = i_m_rvalid ? i_m_rdata : '0;
                end else begin
                    o_if_rvalid = i_m_rvalid;
                    o_if_rdata  = i_m_rvalid ? i_m_rdata : '0;
                end
            end
            default: ;
        endcase
    end

endmodule
